// File: rtl/sm83_fetch_seq.sv
// SM83 instruction fetch/issue sequencer.
// Fetches the opcode, an optional CB byte and 0-2 immediate bytes.
// Hands the assembled bundle to execute and handles the HALT/STOP waits.
package sm83_pkg;
    typedef enum logic [5:0] {
        CTL_NOP,
        CTL_HALT,
        CTL_STOP,
        CTL_LD_R8_R8,
        CTL_ALU_A_R8,
        CTL_LD_R8_D8,
        CTL_LDPTR_HL_D8,
        CTL_JR,
        CTL_JR_COND,
        CTL_ALU_A_D8,
        CTL_LDPTR_A8_A,
        CTL_LDPTR_A_A8,
        CTL_ADD_SP_D8,
        CTL_LD_HL_SP_D8,
        CTL_LD_R16_D16,
        CTL_LDPTR_D16_SP,
        CTL_JP_A16,
        CTL_JP_COND,
        CTL_CALL_A16,
        CTL_CALL_COND_A16,
        CTL_LDPTR_A16_A,
        CTL_LDPTR_A_A16,
        CTL_CB_ROT,
        CTL_CB_BIT,
        CTL_CB_RES,
        CTL_CB_SET
    } ctl_op_t;
endpackage

module sm83_fetch_seq
    import sm83_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          mem_req_o,
    output logic [15:0]   mem_addr_o,
    input  logic [7:0]    mem_rdata_i,
    input  logic          mem_ack_i,
    output logic [7:0]    dec_instr_o,
    output logic          dec_is_instr16_o,
    input  logic          dec_prefix_i,
    input  ctl_op_t       dec_ctl_op_i,
    output logic          exec_valid_o,
    output ctl_op_t       exec_ctl_op_o,
    output logic [7:0]    exec_instr_o,
    output logic          exec_is_cb_o,
    output logic [15:0]   exec_imm_o,
    input  logic          exec_done_i,
    input  logic          pc_load_i,
    input  logic [15:0]   pc_load_val_i,
    input  logic          irq_pending_i,
    input  logic          stop_wake_i,
    output logic [15:0]   pc_o,
    output logic          halted_o
);

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_CB,
        FETCH_IMM_LO,
        FETCH_IMM_HI,
        ISSUE,
        HALTED,
        STOPPED
    } state_t;

    // What the FETCH_IMM_LO byte is for: one immediate, low half of two, or STOP padding.
    typedef enum logic [1:0] {
        IMM_ONE,
        IMM_TWO,
        IMM_PAD
    } imm_mode_t;

    state_t      state_q, state_d;
    imm_mode_t   imm_mode_q, imm_mode_d;
    logic [15:0] pc_q, pc_d;
    logic        mem_req_q, mem_req_d;
    // Set for the one cycle in which the decoder is looking at a freshly acked opcode byte.
    logic        wait_q, wait_d;
    logic [7:0]  dec_instr_q, dec_instr_d;
    logic        dec16_q, dec16_d;
    logic        exec_valid_q, exec_valid_d;
    ctl_op_t     exec_ctl_op_q, exec_ctl_op_d;
    logic [7:0]  exec_instr_q, exec_instr_d;
    logic        exec_is_cb_q, exec_is_cb_d;
    logic [15:0] exec_imm_q, exec_imm_d;
    logic        halted_q, halted_d;
    logic        ack_ok;

    function automatic logic [1:0] imm_count(input ctl_op_t op);
        case (op)
            CTL_LD_R8_D8, CTL_LDPTR_HL_D8, CTL_JR, CTL_JR_COND, CTL_ALU_A_D8,
            CTL_LDPTR_A8_A, CTL_LDPTR_A_A8, CTL_ADD_SP_D8, CTL_LD_HL_SP_D8:
                return 2'd1;
            CTL_LD_R16_D16, CTL_LDPTR_D16_SP, CTL_JP_A16, CTL_JP_COND, CTL_CALL_A16,
            CTL_CALL_COND_A16, CTL_LDPTR_A16_A, CTL_LDPTR_A_A16:
                return 2'd2;
            default:
                return 2'd0;
        endcase
    endfunction

    // Only a request we actually raised in a fetch state can be completed.
    assign ack_ok = mem_req_q && mem_ack_i &&
                    (state_q == FETCH_OP || state_q == FETCH_CB ||
                     state_q == FETCH_IMM_LO || state_q == FETCH_IMM_HI);

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d       = state_q;
        imm_mode_d    = imm_mode_q;
        pc_d          = pc_q;
        mem_req_d     = mem_req_q;
        wait_d        = wait_q;
        dec_instr_d   = dec_instr_q;
        dec16_d       = dec16_q;
        exec_valid_d  = exec_valid_q;
        exec_ctl_op_d = exec_ctl_op_q;
        exec_instr_d  = exec_instr_q;
        exec_is_cb_d  = exec_is_cb_q;
        exec_imm_d    = exec_imm_q;
        halted_d      = halted_q;

        if (ack_ok) begin
            pc_d        = pc_q + 16'd1;
            dec_instr_d = mem_rdata_i;
        end

        case (state_q)
            FETCH_OP: begin
                if (wait_q) begin
                    wait_d        = 1'b0;
                    exec_instr_d  = dec_instr_q;
                    exec_ctl_op_d = dec_ctl_op_i;
                    exec_imm_d    = 16'h0000;
                    exec_is_cb_d  = 1'b0;
                    if (dec_prefix_i) begin
                        state_d   = FETCH_CB;
                        dec16_d   = 1'b1;
                        mem_req_d = 1'b1;
                    end else if (dec_ctl_op_i == CTL_HALT) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else if (dec_ctl_op_i == CTL_STOP) begin
                        state_d    = FETCH_IMM_LO;
                        imm_mode_d = IMM_PAD;
                        mem_req_d  = 1'b1;
                    end else begin
                        case (imm_count(dec_ctl_op_i))
                            2'd1: begin
                                state_d    = FETCH_IMM_LO;
                                imm_mode_d = IMM_ONE;
                                mem_req_d  = 1'b1;
                            end
                            2'd2: begin
                                state_d    = FETCH_IMM_LO;
                                imm_mode_d = IMM_TWO;
                                mem_req_d  = 1'b1;
                            end
                            default: begin
                                state_d      = ISSUE;
                                exec_valid_d = 1'b1;
                            end
                        endcase
                    end
                end else if (ack_ok) begin
                    mem_req_d = 1'b0;
                    wait_d    = 1'b1;
                end else if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end
            end
            FETCH_CB: begin
                if (wait_q) begin
                    wait_d        = 1'b0;
                    exec_instr_d  = dec_instr_q;
                    exec_ctl_op_d = dec_ctl_op_i;
                    exec_is_cb_d  = 1'b1;
                    state_d       = ISSUE;
                    exec_valid_d  = 1'b1;
                end else if (ack_ok) begin
                    mem_req_d = 1'b0;
                    wait_d    = 1'b1;
                end else if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end
            end
            FETCH_IMM_LO: begin
                if (ack_ok) begin
                    case (imm_mode_q)
                        IMM_PAD: begin
                            state_d   = STOPPED;
                            halted_d  = 1'b1;
                            mem_req_d = 1'b0;
                        end
                        IMM_TWO: begin
                            // Request stays high straight into the high-byte fetch.
                            exec_imm_d[7:0] = mem_rdata_i;
                            state_d         = FETCH_IMM_HI;
                        end
                        default: begin
                            exec_imm_d   = {8'h00, mem_rdata_i};
                            state_d      = ISSUE;
                            exec_valid_d = 1'b1;
                            mem_req_d    = 1'b0;
                        end
                    endcase
                end else if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end
            end
            FETCH_IMM_HI: begin
                if (ack_ok) begin
                    exec_imm_d[15:8] = mem_rdata_i;
                    state_d          = ISSUE;
                    exec_valid_d     = 1'b1;
                    mem_req_d        = 1'b0;
                end else if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end
            end
            ISSUE: begin
                if (exec_done_i && exec_valid_q) begin
                    exec_valid_d = 1'b0;
                    dec16_d      = 1'b0;
                    state_d      = FETCH_OP;
                    mem_req_d    = 1'b1;
                    if (pc_load_i) begin
                        pc_d = pc_load_val_i;
                    end
                end
            end
            HALTED: begin
                if (irq_pending_i) begin
                    state_d   = FETCH_OP;
                    halted_d  = 1'b0;
                    mem_req_d = 1'b1;
                end
            end
            STOPPED: begin
                if (stop_wake_i) begin
                    state_d   = FETCH_OP;
                    halted_d  = 1'b0;
                    mem_req_d = 1'b1;
                end
            end
            default: begin
                state_d   = FETCH_OP;
                mem_req_d = 1'b0;
                wait_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over any in-flight handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= FETCH_OP;
            imm_mode_q    <= IMM_ONE;
            pc_q          <= RESET_PC;
            mem_req_q     <= 1'b0;
            wait_q        <= 1'b0;
            dec_instr_q   <= 8'h00;
            dec16_q       <= 1'b0;
            exec_valid_q  <= 1'b0;
            exec_ctl_op_q <= CTL_NOP;
            exec_instr_q  <= 8'h00;
            exec_is_cb_q  <= 1'b0;
            exec_imm_q    <= 16'h0000;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            imm_mode_q    <= imm_mode_d;
            pc_q          <= pc_d;
            mem_req_q     <= mem_req_d;
            wait_q        <= wait_d;
            dec_instr_q   <= dec_instr_d;
            dec16_q       <= dec16_d;
            exec_valid_q  <= exec_valid_d;
            exec_ctl_op_q <= exec_ctl_op_d;
            exec_instr_q  <= exec_instr_d;
            exec_is_cb_q  <= exec_is_cb_d;
            exec_imm_q    <= exec_imm_d;
            halted_q      <= halted_d;
        end
    end

    assign mem_req_o        = mem_req_q;
    assign mem_addr_o       = pc_q;
    assign pc_o             = pc_q;
    assign dec_instr_o      = dec_instr_q;
    assign dec_is_instr16_o = dec16_q;
    assign exec_valid_o     = exec_valid_q;
    assign exec_ctl_op_o    = exec_ctl_op_q;
    assign exec_instr_o     = exec_instr_q;
    assign exec_is_cb_o     = exec_is_cb_q;
    assign exec_imm_o       = exec_imm_q;
    assign halted_o         = halted_q;

endmodule

// File: tb/tb_sm83_fetch_seq.sv
// Self-checking bench for sm83_fetch_seq: table of instruction vectors plus
// hand-written HALT/STOP, stray-handshake and mid-issue reset sequences.
module tb_sm83_fetch_seq;
    import sm83_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic [7:0]  dec_instr;
    logic        dec_is_instr16;
    logic        dec_prefix;
    ctl_op_t     dec_ctl_op;
    logic        exec_valid;
    ctl_op_t     exec_ctl_op;
    logic [7:0]  exec_instr;
    logic        exec_is_cb;
    logic [15:0] exec_imm;
    logic        exec_done = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;
    logic        irq_pending = 1'b0;
    logic        stop_wake = 1'b0;
    logic [15:0] pc;
    logic        halted;

    sm83_fetch_seq #(.RESET_PC(16'h0100)) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .dec_instr_o(dec_instr), .dec_is_instr16_o(dec_is_instr16),
        .dec_prefix_i(dec_prefix), .dec_ctl_op_i(dec_ctl_op),
        .exec_valid_o(exec_valid), .exec_ctl_op_o(exec_ctl_op), .exec_instr_o(exec_instr),
        .exec_is_cb_o(exec_is_cb), .exec_imm_o(exec_imm),
        .exec_done_i(exec_done), .pc_load_i(pc_load), .pc_load_val_i(pc_load_val),
        .irq_pending_i(irq_pending), .stop_wake_i(stop_wake),
        .pc_o(pc), .halted_o(halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-addressed memory; unwritten locations read as 0x00.
    logic [7:0] mem [int];
    logic [15:0] addr_log [$];

    function automatic logic [7:0] rd(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 8'h00;
    endfunction

    // Memory responder: single-cycle ack in the cycle after each new request.
    always @(posedge clk) begin
        if (rst) begin
            mem_ack <= 1'b0;
        end else begin
            mem_ack   <= mem_req && !mem_ack;
            mem_rdata <= rd(mem_addr);
            if (mem_req && !mem_ack) addr_log.push_back(mem_addr);
        end
    end

    // Minimal decoder covering the opcodes used below.
    always_comb begin
        dec_prefix = 1'b0;
        dec_ctl_op = CTL_NOP;
        if (dec_is_instr16) begin
            case (dec_instr[7:6])
                2'd0:    dec_ctl_op = CTL_CB_ROT;
                2'd1:    dec_ctl_op = CTL_CB_BIT;
                2'd2:    dec_ctl_op = CTL_CB_RES;
                default: dec_ctl_op = CTL_CB_SET;
            endcase
        end else begin
            case (dec_instr)
                8'h00:   dec_ctl_op = CTL_NOP;
                8'hCB:   dec_prefix = 1'b1;
                8'h3E:   dec_ctl_op = CTL_LD_R8_D8;
                8'hC3:   dec_ctl_op = CTL_JP_A16;
                8'h18:   dec_ctl_op = CTL_JR;
                8'h01:   dec_ctl_op = CTL_LD_R16_D16;
                8'h76:   dec_ctl_op = CTL_HALT;
                8'h10:   dec_ctl_op = CTL_STOP;
                default: dec_ctl_op = CTL_LD_R8_R8;
            endcase
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return mem_req;
            1:       return exec_valid;
            default: return halted;
        endcase
    endfunction

    // Bounded wait at negedges for a DUT output to go high.
    task automatic wait_hi(input int sel, input string name);
        int n = 0;
        while (sig(sel) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'b0, sig(sel)}, 32'd1);
    endtask

    task automatic pulse_done(input logic ld, input logic [15:0] val);
        exec_done   = 1'b1;
        pc_load     = ld;
        pc_load_val = val;
        @(negedge clk);
        exec_done = 1'b0;
        pc_load   = 1'b0;
    endtask

    typedef struct {
        logic [15:0] start;
        logic [7:0]  b0, b1, b2;
        ctl_op_t     op;
        logic [15:0] imm;
        logic        cb;
        logic [7:0]  instr;
        int          lat;
        logic        ld;
        logic [15:0] ld_val;
        logic [15:0] next_pc;
    } vec_t;

    vec_t vecs [6];

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"},    {31'b0, mem_req},        32'd0);
        chk({tag, "_exec_valid"}, {31'b0, exec_valid},     32'd0);
        chk({tag, "_exec_imm"},   {16'b0, exec_imm},       32'd0);
        chk({tag, "_exec_is_cb"}, {31'b0, exec_is_cb},     32'd0);
        chk({tag, "_exec_op"},    32'(exec_ctl_op),        32'(CTL_NOP));
        chk({tag, "_exec_instr"}, {24'b0, exec_instr},     32'd0);
        chk({tag, "_dec_instr"},  {24'b0, dec_instr},      32'd0);
        chk({tag, "_dec16"},      {31'b0, dec_is_instr16}, 32'd0);
        chk({tag, "_halted"},     {31'b0, halted},         32'd0);
        chk({tag, "_pc"},         {16'b0, pc},             32'h0100);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] imm_seen;
        logic        bad;
        int          t0;
        int          lat;

        //              start    b0     b1     b2     op               imm      cb    instr  lat ld    ld_val    next_pc
        vecs[0] = '{16'h0100, 8'h00, 8'h00, 8'h00, CTL_NOP,        16'h0000, 1'b0, 8'h00, 3, 1'b0, 16'h0000, 16'h0101};
        vecs[1] = '{16'h0101, 8'h3E, 8'h42, 8'h00, CTL_LD_R8_D8,   16'h0042, 1'b0, 8'h3E, 5, 1'b0, 16'h0000, 16'h0103};
        vecs[2] = '{16'h0103, 8'hC3, 8'h34, 8'h12, CTL_JP_A16,     16'h1234, 1'b0, 8'hC3, 7, 1'b1, 16'h1234, 16'h1234};
        vecs[3] = '{16'h1234, 8'hCB, 8'h37, 8'h00, CTL_CB_ROT,     16'h0000, 1'b1, 8'h37, 6, 1'b0, 16'h0000, 16'h1236};
        vecs[4] = '{16'h1236, 8'h18, 8'hFE, 8'h00, CTL_JR,         16'h00FE, 1'b0, 8'h18, 5, 1'b1, 16'hFFFF, 16'hFFFF};
        vecs[5] = '{16'hFFFF, 8'h01, 8'hAA, 8'hBB, CTL_LD_R16_D16, 16'hBBAA, 1'b0, 8'h01, 7, 1'b0, 16'h0000, 16'h0002};

        // Preload in table order: later vectors overwrite unused tail bytes of earlier ones.
        for (int i = 0; i < 6; i++) begin
            a = vecs[i].start;        mem[int'(a)] = vecs[i].b0;
            a = vecs[i].start + 16'd1; mem[int'(a)] = vecs[i].b1;
            a = vecs[i].start + 16'd2; mem[int'(a)] = vecs[i].b2;
        end
        // HALT, STOP + pad, LD A,0x55, CB SWAP A.
        mem[16'h0002] = 8'h76;
        mem[16'h0003] = 8'h10;
        mem[16'h0004] = 8'h99;
        mem[16'h0005] = 8'h3E;
        mem[16'h0006] = 8'h55;
        mem[16'h0007] = 8'hCB;
        mem[16'h0008] = 8'h37;

        repeat (3) @(negedge clk);
        check_reset_outputs("init");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (i == 5) addr_log.delete();
            wait_hi(0, $sformatf("v%0d_req_timeout", i));
            chk($sformatf("v%0d_addr", i), {16'b0, mem_addr}, {16'b0, vecs[i].start});
            t0 = cyc;
            wait_hi(1, $sformatf("v%0d_valid_timeout", i));
            lat = cyc - t0;
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_op", i),    32'(exec_ctl_op),        32'(vecs[i].op));
            chk($sformatf("v%0d_imm", i),   {16'b0, exec_imm},       {16'b0, vecs[i].imm});
            chk($sformatf("v%0d_cb", i),    {31'b0, exec_is_cb},     {31'b0, vecs[i].cb});
            chk($sformatf("v%0d_instr", i), {24'b0, exec_instr},     {24'b0, vecs[i].instr});
            chk($sformatf("v%0d_dec16", i), {31'b0, dec_is_instr16}, {31'b0, vecs[i].cb});
            chk($sformatf("v%0d_req_low", i), {31'b0, mem_req},      32'd0);
            imm_seen = exec_imm;
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_hold_valid", i), {31'b0, exec_valid}, 32'd1);
            chk($sformatf("v%0d_hold_imm", i),   {16'b0, exec_imm},   {16'b0, imm_seen});
            if (i == 5) begin
                chk("wrap_log_len", addr_log.size(), 3);
                if (addr_log.size() == 3) begin
                    chk("wrap_addr0", {16'b0, addr_log[0]}, 32'hFFFF);
                    chk("wrap_addr1", {16'b0, addr_log[1]}, 32'h0000);
                    chk("wrap_addr2", {16'b0, addr_log[2]}, 32'h0001);
                end
            end
            pulse_done(vecs[i].ld, vecs[i].ld_val);
            chk($sformatf("v%0d_valid_drop", i), {31'b0, exec_valid}, 32'd0);
            chk($sformatf("v%0d_next_pc", i),    {16'b0, mem_addr},   {16'b0, vecs[i].next_pc});
            chk($sformatf("v%0d_next_req", i),   {31'b0, mem_req},    32'd1);
        end

        // HALT at 0x0002.
        wait_hi(2, "halt_timeout");
        chk("halt_req", {31'b0, mem_req}, 32'd0);
        chk("halt_pc",  {16'b0, pc},      32'h0003);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 16'h0003) bad = 1'b1;
        end
        chk("halt_10_cycles", {31'b0, bad}, 32'd0);
        irq_pending = 1'b1;
        @(negedge clk);
        irq_pending = 1'b0;
        chk("halt_wake_halted", {31'b0, halted},  32'd0);
        chk("halt_wake_req",    {31'b0, mem_req}, 32'd1);
        chk("halt_wake_addr",   {16'b0, mem_addr}, 32'h0003);

        // STOP at 0x0003 swallows the pad byte at 0x0004.
        wait_hi(2, "stop_timeout");
        chk("stop_pc",    {16'b0, pc},         32'h0005);
        chk("stop_req",   {31'b0, mem_req},    32'd0);
        chk("stop_valid", {31'b0, exec_valid}, 32'd0);
        irq_pending = 1'b1;
        @(negedge clk);
        irq_pending = 1'b0;
        @(negedge clk);
        chk("stop_ignores_irq", {31'b0, halted}, 32'd1);
        stop_wake = 1'b1;
        @(negedge clk);
        stop_wake = 1'b0;
        chk("stop_wake_halted", {31'b0, halted},   32'd0);
        chk("stop_wake_addr",   {16'b0, mem_addr}, 32'h0005);

        // exec_done while nothing is issued must not redirect.
        pulse_done(1'b1, 16'h7777);
        chk("stray_done_addr", {16'b0, mem_addr}, 32'h0005);
        wait_hi(1, "ld55_valid_timeout");
        chk("ld55_imm",   {16'b0, exec_imm},   32'h0055);
        chk("ld55_instr", {24'b0, exec_instr}, 32'h3E);
        pulse_done(1'b0, 16'h0000);
        chk("ld55_next_pc", {16'b0, mem_addr}, 32'h0007);

        // Reset in the middle of a CB bundle handshake.
        wait_hi(1, "cb_valid_timeout");
        chk("cb_pre_reset_cb", {31'b0, exec_is_cb}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        wait_hi(0, "post_rst_req_timeout");
        chk("post_rst_addr", {16'b0, mem_addr}, 32'h0100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
